lsu_mem_ctrl: RTL and testbench

Load/store unit for the MEM stage of the pipelined RISC-V core. It consumes the decoded width (whb) and signedness (su) controls together with the ALU-computed address. It drives a word-addressed data-memory request/grant/rvalid handshake and generates byte enables and lane-shifted store data. It returns sign- or zero-extended load data and stalls the pipeline until each access completes.

---
 rtl/lsu_mem_ctrl.sv | 207 ++++++++++++++++++++
 tb/tb_lsu_mem_ctrl.sv | 171 +++++++++++++++++
 2 files changed

// File: rtl/lsu_mem_ctrl.sv
// lsu_mem_ctrl -- MEM-stage load/store unit.
//
// Turns a decoded load/store (width whb, signedness su, byte address) into a
// word-addressed request/grant/rvalid memory transaction. It generates byte
// enables and lane-replicated store data, and returns extended load data. The
// upstream pipeline is stalled until the access retires.
//
// Ports
//   clk, rst_n        clock; synchronous active-low reset
//   req_valid/we/addr/wdata, whb, su
//                     MEM-stage request (whb: 00 byte, 01 half, 10 word)
//   stall             hold upstream stages
//   done              1-cycle retire pulse
//   misalign/bus_err  1-cycle error flags, raised together with done
//   load_data         registered extended load result
//   mem_req/we/addr/be/wdata
//                     memory request; held until mem_gnt
//   mem_gnt, mem_rvalid, mem_rdata
//                     memory handshake and read data
module lsu_mem_ctrl #(
  parameter int TIMEOUT = 16,
  parameter int ADDR_W  = 32
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              req_valid,
  input  logic              req_we,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic [31:0]       req_wdata,
  input  logic [1:0]        whb,
  input  logic              su,
  output logic              stall,
  output logic              done,
  output logic [31:0]       load_data,
  output logic              misalign,
  output logic              bus_err,
  output logic              mem_req,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [3:0]        mem_be,
  output logic [31:0]       mem_wdata,
  input  logic              mem_gnt,
  input  logic              mem_rvalid,
  input  logic [31:0]       mem_rdata
);

  typedef enum logic [2:0] {S_IDLE, S_REQ, S_WAIT, S_DONE, S_ERR} state_e;

  localparam logic [7:0] TO_LAST = 8'(TIMEOUT - 1);

  state_e            state_q;
  logic [7:0]        cnt_q;
  logic              we_q, su_q;
  logic [1:0]        whb_q, off_q;
  logic              mem_req_q, mem_we_q;
  logic [ADDR_W-1:0] mem_addr_q;
  logic [3:0]        mem_be_q;
  logic [31:0]       mem_wdata_q;
  logic              done_q, misalign_q, bus_err_q;
  logic [31:0]       load_data_q;

  // ---------------------------------------------------------------------------
  // Request decode
  // ---------------------------------------------------------------------------
  logic        bad_req;
  logic [3:0]  be_d;
  logic [31:0] wd_d;

  assign bad_req = (whb == 2'b11)
                 | ((whb == 2'b01) & req_addr[0])
                 | ((whb == 2'b10) & (req_addr[1:0] != 2'b00));

  // Per byte lane: enable and which source byte lands in this lane.
  for (genvar g = 0; g < 4; g++) begin : g_lane
    localparam logic [1:0] LN = 2'(g);
    localparam int         HB = g % 2;
    assign be_d[g] = (whb == 2'b00) ? (req_addr[1:0] == LN) :
                     (whb == 2'b01) ? (req_addr[1] == LN[1]) : 1'b1;
    assign wd_d[8*g +: 8] = (whb == 2'b00) ? req_wdata[7:0] :
                            (whb == 2'b01) ? req_wdata[8*HB +: 8] :
                                             req_wdata[8*g +: 8];
  end

  // ---------------------------------------------------------------------------
  // Load extraction: bring the addressed lane down to bit 0, then extend.
  // ---------------------------------------------------------------------------
  logic [31:0] rd_sh, ld_ext;

  assign rd_sh = mem_rdata >> {off_q, 3'b000};

  always_comb begin
    ld_ext = rd_sh;
    case (whb_q)
      2'b00:   ld_ext = {{24{su_q & rd_sh[7]}},  rd_sh[7:0]};
      2'b01:   ld_ext = {{16{su_q & rd_sh[15]}}, rd_sh[15:0]};
      default: ld_ext = rd_sh;
    endcase
  end

  logic to_hit;
  assign to_hit = (cnt_q == TO_LAST);

  // ---------------------------------------------------------------------------
  // Control FSM
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q     <= S_IDLE;
      cnt_q       <= '0;
      we_q        <= 1'b0;
      su_q        <= 1'b0;
      whb_q       <= 2'b00;
      off_q       <= 2'b00;
      mem_req_q   <= 1'b0;
      mem_we_q    <= 1'b0;
      mem_addr_q  <= '0;
      mem_be_q    <= 4'b0000;
      mem_wdata_q <= '0;
      done_q      <= 1'b0;
      misalign_q  <= 1'b0;
      bus_err_q   <= 1'b0;
      load_data_q <= '0;
    end else begin
      done_q     <= 1'b0;
      misalign_q <= 1'b0;
      bus_err_q  <= 1'b0;
      case (state_q)
        S_IDLE: begin
          if (req_valid) begin
            if (bad_req) begin
              // Rejected without touching memory.
              state_q    <= S_ERR;
              done_q     <= 1'b1;
              misalign_q <= 1'b1;
            end else begin
              state_q     <= S_REQ;
              cnt_q       <= '0;
              we_q        <= req_we;
              whb_q       <= whb;
              su_q        <= su;
              off_q       <= req_addr[1:0];
              mem_req_q   <= 1'b1;
              mem_we_q    <= req_we;
              mem_addr_q  <= {req_addr[ADDR_W-1:2], 2'b00};
              mem_be_q    <= be_d;
              mem_wdata_q <= wd_d;
            end
          end
        end
        S_REQ: begin
          cnt_q <= cnt_q + 8'd1;
          // The request side is released once granted or abandoned.
          if (mem_gnt || to_hit) begin
            mem_req_q   <= 1'b0;
            mem_we_q    <= 1'b0;
            mem_addr_q  <= '0;
            mem_be_q    <= 4'b0000;
            mem_wdata_q <= '0;
          end
          // Completion beats the timeout when both land in the same cycle.
          if (mem_gnt && (we_q || mem_rvalid)) begin
            state_q <= S_DONE;
            done_q  <= 1'b1;
            if (!we_q) load_data_q <= ld_ext;
          end else if (to_hit) begin
            state_q   <= S_ERR;
            done_q    <= 1'b1;
            bus_err_q <= 1'b1;
          end else if (mem_gnt) begin
            state_q <= S_WAIT;
          end
        end
        S_WAIT: begin
          cnt_q <= cnt_q + 8'd1;
          if (mem_rvalid) begin
            state_q     <= S_DONE;
            done_q      <= 1'b1;
            load_data_q <= ld_ext;
          end else if (to_hit) begin
            state_q   <= S_ERR;
            done_q    <= 1'b1;
            bus_err_q <= 1'b1;
          end
        end
        S_DONE:  state_q <= S_IDLE;
        S_ERR:   state_q <= S_IDLE;
        default: state_q <= S_IDLE;
      endcase
    end
  end

  // Stall is combinational in IDLE so the request is held the cycle it shows up.
  assign stall = ((state_q == S_IDLE) & req_valid)
               | (state_q == S_REQ)
               | (state_q == S_WAIT);

  assign done      = done_q;
  assign misalign  = misalign_q;
  assign bus_err   = bus_err_q;
  assign load_data = load_data_q;
  assign mem_req   = mem_req_q;
  assign mem_we    = mem_we_q;
  assign mem_addr  = mem_addr_q;
  assign mem_be    = mem_be_q;
  assign mem_wdata = mem_wdata_q;

endmodule

// File: tb/tb_lsu_mem_ctrl.sv
module tb_lsu_mem_ctrl;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        req_valid = 1'b0, req_we = 1'b0, su = 1'b0;
  logic [31:0] req_addr = '0, req_wdata = '0;
  logic [1:0]  whb = 2'b00;
  logic        stall, done, misalign, bus_err;
  logic [31:0] load_data;
  logic        mem_req, mem_we;
  logic [31:0] mem_addr;
  logic [3:0]  mem_be;
  logic [31:0] mem_wdata;
  logic        mem_gnt = 1'b0, mem_rvalid = 1'b0;
  logic [31:0] mem_rdata = '0;

  lsu_mem_ctrl #(.TIMEOUT(16), .ADDR_W(32)) dut (
    .clk(clk), .rst_n(rst_n),
    .req_valid(req_valid), .req_we(req_we), .req_addr(req_addr),
    .req_wdata(req_wdata), .whb(whb), .su(su),
    .stall(stall), .done(done), .load_data(load_data),
    .misalign(misalign), .bus_err(bus_err),
    .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr),
    .mem_be(mem_be), .mem_wdata(mem_wdata),
    .mem_gnt(mem_gnt), .mem_rvalid(mem_rvalid), .mem_rdata(mem_rdata)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct { int cyc; logic mis; logic berr; logic [31:0] ld; } rsp_t;
  typedef struct { logic we; logic [31:0] addr; logic [3:0] be; logic [31:0] wd; } mreq_t;

  rsp_t  rq[$];
  mreq_t mq[$];
  int    n_cmp = 0;
  int    n_bad = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s @cyc %0d: got %h expected %h", nm, cyc, act, exp);
    end
  endtask

  // Monitor: response and memory-request scoreboards.
  logic prev_req = 1'b0;
  always @(negedge clk) begin
    rsp_t  r;
    mreq_t m;
    if (done) begin
      if (rq.size() == 0) chk("unexpected_done", 32'(done), 32'd0);
      else begin
        r = rq.pop_front();
        chk("done_cycle", 32'(cyc), 32'(r.cyc));
        chk("misalign",   32'(misalign), 32'(r.mis));
        chk("bus_err",    32'(bus_err), 32'(r.berr));
        chk("load_data",  load_data, r.ld);
        chk("stall_done", 32'(stall), 32'd0);
      end
    end else if (misalign || bus_err) begin
      chk("flag_without_done", {30'd0, misalign, bus_err}, 32'd0);
    end
    if (mem_req) begin
      if (mq.size() == 0) chk("unexpected_mem_req", 32'(mem_req), 32'd0);
      else begin
        m = mq[0];
        chk("mem_we",    32'(mem_we), 32'(m.we));
        chk("mem_addr",  mem_addr, m.addr);
        chk("mem_be",    32'(mem_be), 32'(m.be));
        chk("mem_wdata", mem_wdata, m.wd);
      end
    end
    if (prev_req && !mem_req && mq.size() > 0) void'(mq.pop_front());
    prev_req = mem_req;
  end

  task automatic chk_zero(input string nm);
    chk({nm, "_stall"},  32'(stall), 32'd0);
    chk({nm, "_done"},   32'(done), 32'd0);
    chk({nm, "_flags"},  {30'd0, misalign, bus_err}, 32'd0);
    chk({nm, "_ld"},     load_data, 32'd0);
    chk({nm, "_mreq"},   {30'd0, mem_req, mem_we}, 32'd0);
    chk({nm, "_maddr"},  mem_addr, 32'd0);
    chk({nm, "_mbe"},    32'(mem_be), 32'd0);
    chk({nm, "_mwdata"}, mem_wdata, 32'd0);
  endtask

  // One access. gnt_dly<0: never grant. rv_dly: cycles from gnt to rvalid (loads).
  task automatic issue(input logic we, input logic [31:0] addr, input logic [31:0] wd,
                       input logic [1:0] w, input logic s,
                       input int gnt_dly, input int rv_dly, input logic [31:0] rdata,
                       input logic exp_mem, input logic [31:0] emaddr, input logic [3:0] ebe,
                       input logic [31:0] ewd, input int done_off,
                       input logic emis, input logic eberr, input logic [31:0] eld);
    int rc;
    @(posedge clk); #1;
    rc = cyc;
    req_valid = 1'b1; req_we = we; req_addr = addr; req_wdata = wd; whb = w; su = s;
    if (exp_mem) mq.push_back('{we, emaddr, ebe, ewd});
    rq.push_back('{rc + done_off, emis, eberr, eld});
    #3 chk("stall_req", 32'(stall), 32'd1);
    @(posedge clk); #1;
    req_valid = 1'b0; req_wdata = '0;
    #3 chk("stall_cyc1", 32'(stall), 32'(exp_mem));
    if (gnt_dly >= 0) begin
      repeat (gnt_dly) begin @(posedge clk); #1; end
      mem_gnt = 1'b1;
      if (!we && rv_dly == 0) begin mem_rvalid = 1'b1; mem_rdata = rdata; end
      @(posedge clk); #1;
      mem_gnt = 1'b0; mem_rvalid = 1'b0;
      if (!we && rv_dly > 0) begin
        repeat (rv_dly - 1) begin @(posedge clk); #1; end
        mem_rvalid = 1'b1; mem_rdata = rdata;
        @(posedge clk); #1;
        mem_rvalid = 1'b0;
      end
    end
    while (cyc < rc + done_off + 2) @(posedge clk);
  endtask

  initial begin
    int rc;
    repeat (3) @(posedge clk);
    #1 chk_zero("reset");
    rst_n = 1'b1;

    //    we  addr          wdata         whb  su gnt rv rdata          mem maddr         be       mwdata        off mis berr ld
    issue(1, 32'h100, 32'hDEADBEEF, 2'b10, 0, 0, 0, 32'h0,        1, 32'h100, 4'b1111, 32'hDEADBEEF, 2, 0, 0, 32'h0);
    issue(0, 32'h103, 32'h0,        2'b00, 1, 0, 2, 32'h80FF1234, 1, 32'h100, 4'b1000, 32'h0,        4, 0, 0, 32'hFFFFFF80);
    issue(0, 32'h103, 32'h0,        2'b00, 0, 0, 2, 32'h80FF1234, 1, 32'h100, 4'b1000, 32'h0,        4, 0, 0, 32'h00000080);
    issue(0, 32'h102, 32'h0,        2'b01, 1, 0, 0, 32'h80010000, 1, 32'h100, 4'b1100, 32'h0,        2, 0, 0, 32'hFFFF8001);
    issue(0, 32'h102, 32'h0,        2'b01, 0, 1, 1, 32'h80010000, 1, 32'h100, 4'b1100, 32'h0,        4, 0, 0, 32'h00008001);
    issue(1, 32'h201, 32'h1234,     2'b01, 0, -1, 0, 32'h0,       0, 32'h0,   4'b0000, 32'h0,        1, 1, 0, 32'h00008001);
    issue(0, 32'h302, 32'h0,        2'b10, 0, -1, 0, 32'h0,       0, 32'h0,   4'b0000, 32'h0,        1, 1, 0, 32'h00008001);
    issue(0, 32'h400, 32'h0,        2'b11, 0, -1, 0, 32'h0,       0, 32'h0,   4'b0000, 32'h0,        1, 1, 0, 32'h00008001);
    issue(0, 32'h500, 32'h0,        2'b10, 0, -1, 0, 32'h0,       1, 32'h500, 4'b1111, 32'h0,       17, 0, 1, 32'h00008001);

    // Reset while in WAIT: abandoned, no done, stray rvalid afterwards ignored.
    @(posedge clk); #1;
    rc = cyc;
    req_valid = 1'b1; req_we = 1'b0; req_addr = 32'h600; whb = 2'b10; su = 1'b0;
    mq.push_back('{1'b0, 32'h600, 4'b1111, 32'h0});
    @(posedge clk); #1;
    req_valid = 1'b0; mem_gnt = 1'b1;
    @(posedge clk); #1;
    mem_gnt = 1'b0; rst_n = 1'b0;
    @(posedge clk); #1;
    rst_n = 1'b1; mem_rvalid = 1'b1; mem_rdata = 32'h11223344;
    #3 chk_zero("midreset");
    @(posedge clk); #1;
    mem_rvalid = 1'b0;
    while (cyc < rc + 7) @(posedge clk);

    issue(1, 32'h001, 32'h000000AB, 2'b00, 0, 0, 0, 32'h0,        1, 32'h000, 4'b0010, 32'hABABABAB, 2, 0, 0, 32'h0);
    issue(1, 32'h202, 32'h12345678, 2'b01, 0, 3, 0, 32'h0,        1, 32'h200, 4'b1100, 32'h56785678, 5, 0, 0, 32'h0);
    // Grant on the last timeout cycle: completion wins, no bus error.
    issue(1, 32'h700, 32'hCAFEF00D, 2'b10, 0, 15, 0, 32'h0,       1, 32'h700, 4'b1111, 32'hCAFEF00D, 17, 0, 0, 32'h0);

    repeat (3) @(posedge clk);
    #1;
    chk("rsp_q_drained", 32'(rq.size()), 32'd0);
    chk("mem_q_drained", 32'(mq.size()), 32'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
